// File: rtl/zeroriscy_vec_pkg.sv
// Shared types and constants for the zero-riscy vector execute path.
package zeroriscy_vec_pkg;

    localparam int unsigned VEC_LANES  = 4;
    localparam int unsigned VEC_LANE_W = 32;

    typedef logic [VEC_LANES-1:0][VEC_LANE_W-1:0] vec_t;

    typedef enum logic [3:0] {
        VEC_ADD = 4'd0,
        VEC_SUB = 4'd1,
        VEC_SLL = 4'd2,
        VEC_SRL = 4'd3,
        VEC_SRA = 4'd4
    } vec_op_e;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        WB
    } vec_state_e;

endpackage

// File: rtl/zeroriscy_vector_alu.sv
// Stateless 4-lane x 32-bit vector ALU; flags any opcode outside the defined set.
module zeroriscy_vector_alu
    import zeroriscy_vec_pkg::*;
(
    input  logic [3:0] op,
    input  vec_t       arg_a,
    input  vec_t       arg_b,
    output vec_t       res,
    output logic       illegal
);

    always_comb begin
        res     = '0;
        illegal = 1'b0;
        for (int unsigned i = 0; i < VEC_LANES; i++) begin
            case (op)
                VEC_ADD: res[i] = arg_a[i] + arg_b[i];
                VEC_SUB: res[i] = arg_a[i] - arg_b[i];
                VEC_SLL: res[i] = arg_a[i] << arg_b[i][4:0];
                VEC_SRL: res[i] = arg_a[i] >> arg_b[i][4:0];
                VEC_SRA: res[i] = $unsigned($signed(arg_a[i]) >>> arg_b[i][4:0]);
                default: begin
                    res[i]  = '0;
                    illegal = 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/zeroriscy_vector_ex_ctrl.sv
// Vector execute controller: FSM, 8-entry vector register file and operand latches.
// Optional scalar broadcast of operand B enabled by defining ZERORISCY_VEC_BCAST_EN.
module zeroriscy_vector_ex_ctrl
    import zeroriscy_vec_pkg::*;
#(
    parameter int unsigned NUM_VREGS = 8,
    parameter int unsigned VREG_AW   = $clog2(NUM_VREGS)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid_i,
    output logic               cmd_ready_o,
    input  logic [3:0]         cmd_opcode_i,
    input  logic [VREG_AW-1:0] cmd_rd_i,
    input  logic [VREG_AW-1:0] cmd_rs1_i,
    input  logic [VREG_AW-1:0] cmd_rs2_i,
    input  logic               cmd_bcast_i,
    input  logic [31:0]        cmd_scalar_i,
    input  logic               wr_valid_i,
    output logic               wr_ready_o,
    input  logic [VREG_AW-1:0] wr_addr_i,
    input  logic [127:0]       wr_data_i,
    input  logic [VREG_AW-1:0] rd_addr_i,
    output logic [127:0]       rd_data_o,
    output logic               done_o,
    output logic               err_o,
    output logic [127:0]       result_o,
    output logic               busy_o
);

    vec_state_e         state;
    vec_t               vregs [NUM_VREGS];
    logic [3:0]         op_q;
    logic [VREG_AW-1:0] rd_q;
    vec_t               arg_a_q;
    vec_t               arg_b_q;
    vec_t               res_q;
    logic               illegal_q;
    logic               done_q;
    logic               err_q;

    vec_t               arg_b_next;
    vec_t               alu_res;
    logic               alu_illegal;

`ifdef ZERORISCY_VEC_BCAST_EN
    always_comb begin
        arg_b_next = vregs[cmd_rs2_i];
        if (cmd_bcast_i) begin
            arg_b_next = {VEC_LANES{cmd_scalar_i}};
        end
    end
`else
    logic unused_bcast;
    assign unused_bcast = ^{cmd_bcast_i, cmd_scalar_i};

    always_comb begin
        arg_b_next = vregs[cmd_rs2_i];
    end
`endif

    zeroriscy_vector_alu u_alu (
        .op      (op_q),
        .arg_a   (arg_a_q),
        .arg_b   (arg_b_q),
        .res     (alu_res),
        .illegal (alu_illegal)
    );

    // Ready signals depend on state only, keeping them free of input paths.
    assign cmd_ready_o = (state == IDLE);
    assign wr_ready_o  = (state != WB);
    assign busy_o      = (state != IDLE);
    assign done_o      = done_q;
    assign err_o       = err_q;
    assign result_o    = res_q;
    assign rd_data_o   = vregs[rd_addr_i];

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            op_q      <= '0;
            rd_q      <= '0;
            arg_a_q   <= '0;
            arg_b_q   <= '0;
            res_q     <= '0;
            illegal_q <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            for (int unsigned i = 0; i < NUM_VREGS; i++) begin
                vregs[i] <= '0;
            end
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;

            // Operands below sample the pre-edge contents, so a same-cycle scalar write is not bypassed.
            if (wr_valid_i && wr_ready_o) begin
                vregs[wr_addr_i] <= wr_data_i;
            end

            case (state)
                IDLE: begin
                    if (cmd_valid_i) begin
                        op_q    <= cmd_opcode_i;
                        rd_q    <= cmd_rd_i;
                        arg_a_q <= vregs[cmd_rs1_i];
                        arg_b_q <= arg_b_next;
                        state   <= EXEC;
                    end
                end
                EXEC: begin
                    res_q     <= alu_res;
                    illegal_q <= alu_illegal;
                    done_q    <= 1'b1;
                    err_q     <= alu_illegal;
                    state     <= WB;
                end
                WB: begin
                    if (!illegal_q) begin
                        vregs[rd_q] <= res_q;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_zeroriscy_vector_ex_ctrl.sv
// Scoreboard bench for zeroriscy_vector_ex_ctrl: issued commands queue expectations, a monitor checks retirements.
module tb_zeroriscy_vector_ex_ctrl;
    import zeroriscy_vec_pkg::*;

    localparam int unsigned AW = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [3:0]    cmd_opcode = '0;
    logic [AW-1:0] cmd_rd = '0, cmd_rs1 = '0, cmd_rs2 = '0;
    logic          cmd_bcast = 1'b0;
    logic [31:0]   cmd_scalar = '0;
    logic          wr_valid = 1'b0;
    logic          wr_ready;
    logic [AW-1:0] wr_addr = '0;
    logic [127:0]  wr_data = '0;
    logic [AW-1:0] rd_addr = '0;
    logic [127:0]  rd_data;
    logic          done, err, busy;
    logic [127:0]  result;

    typedef struct {
        logic [127:0] res;
        logic         err;
        int           cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    zeroriscy_vector_ex_ctrl #(.NUM_VREGS(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid_i  (cmd_valid),
        .cmd_ready_o  (cmd_ready),
        .cmd_opcode_i (cmd_opcode),
        .cmd_rd_i     (cmd_rd),
        .cmd_rs1_i    (cmd_rs1),
        .cmd_rs2_i    (cmd_rs2),
        .cmd_bcast_i  (cmd_bcast),
        .cmd_scalar_i (cmd_scalar),
        .wr_valid_i   (wr_valid),
        .wr_ready_o   (wr_ready),
        .wr_addr_i    (wr_addr),
        .wr_data_i    (wr_data),
        .rd_addr_i    (rd_addr),
        .rd_data_o    (rd_data),
        .done_o       (done),
        .err_o        (err),
        .result_o     (result),
        .busy_o       (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    function automatic logic [127:0] vec4(input logic [31:0] l3, l2, l1, l0);
        return {l3, l2, l1, l0};
    endfunction

    function automatic logic [127:0] splat(input logic [31:0] v);
        return {v, v, v, v};
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Retirement monitor: done is expected exactly one cycle after the acceptance edge's cycle count.
    always @(negedge clk) begin
        if (!rst && done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("result", result, e.res);
                check("err", {127'b0, err}, {127'b0, e.err});
                check("done_latency", cyc, e.cyc);
            end
        end
    end

    task automatic wr(input int addr, input logic [127:0] data);
        wr_valid = 1'b1;
        wr_addr  = AW'(addr);
        wr_data  = data;
        @(posedge clk); #1;
        wr_valid = 1'b0;
    endtask

    task automatic check_reg(input string name, input int idx, input logic [127:0] exp);
        rd_addr = AW'(idx);
        #1;
        check(name, rd_data, exp);
    endtask

    task automatic drive_cmd(input logic [3:0] op, input int rd, rs1, rs2,
                             input logic bc, input logic [31:0] sc);
        cmd_opcode = op;
        cmd_rd     = AW'(rd);
        cmd_rs1    = AW'(rs1);
        cmd_rs2    = AW'(rs2);
        cmd_bcast  = bc;
        cmd_scalar = sc;
        cmd_valid  = 1'b1;
    endtask

    task automatic push_exp(input logic [127:0] res, input logic e);
        exp_t x;
        x.res = res;
        x.err = e;
        x.cyc = cyc + 1;
        sb.push_back(x);
    endtask

    task automatic start(input logic [3:0] op, input int rd, rs1, rs2,
                         input logic bc, input logic [31:0] sc,
                         input logic [127:0] exp_res, input logic exp_err, input bit track);
        int n = 0;
        while (!cmd_ready && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        if (!cmd_ready) check("cmd_ready_timeout", 0, 1);
        drive_cmd(op, rd, rs1, rs2, bc, sc);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        if (track) push_exp(exp_res, exp_err);
    endtask

    task automatic retire();
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        int acc_a;
        int acc_b;

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        check("rst_busy", {127'b0, busy}, 0);
        check("rst_done", {127'b0, done}, 0);
        check("rst_err", {127'b0, err}, 0);
        check("rst_result", result, 0);
        check("rst_cmd_ready", {127'b0, cmd_ready}, 1);
        check("rst_wr_ready", {127'b0, wr_ready}, 1);
        check_reg("rst_v3", 3, 0);

        // ADD with lane wrap
        wr(1, vec4(32'hFFFF_FFFF, 32'd3, 32'd2, 32'd1));
        wr(2, splat(32'd1));
        check_reg("load_v1", 1, vec4(32'hFFFF_FFFF, 32'd3, 32'd2, 32'd1));
        start(VEC_ADD, 3, 1, 2, 1'b0, 32'd0, vec4(32'd0, 32'd4, 32'd3, 32'd2), 1'b0, 1'b1);
        check("exec_busy", {127'b0, busy}, 1);
        check("exec_cmd_ready", {127'b0, cmd_ready}, 0);
        check("exec_wr_ready", {127'b0, wr_ready}, 1);
        @(posedge clk); #1;
        check("wb_wr_ready", {127'b0, wr_ready}, 0);
        check("wb_done", {127'b0, done}, 1);
        @(posedge clk); #1;
        check("idle_busy", {127'b0, busy}, 0);
        check("idle_cmd_ready", {127'b0, cmd_ready}, 1);
        check_reg("add_v3", 3, vec4(32'd0, 32'd4, 32'd3, 32'd2));

        // Shifts
        wr(1, splat(32'h8000_0000));
        wr(2, splat(32'd4));
        start(VEC_SRA, 5, 1, 2, 1'b0, 32'd0, splat(32'hF800_0000), 1'b0, 1'b1);
        retire();
        start(VEC_SRL, 6, 1, 2, 1'b0, 32'd0, splat(32'h0800_0000), 1'b0, 1'b1);
        retire();
        check_reg("sra_v5", 5, splat(32'hF800_0000));
        check_reg("srl_v6", 6, splat(32'h0800_0000));
        wr(0, splat(32'd3));
        wr(2, splat(32'd36));
        start(VEC_SLL, 7, 0, 2, 1'b0, 32'd0, splat(32'h30), 1'b0, 1'b1);
        retire();
        check_reg("sll36_v7", 7, splat(32'h30));

        // Illegal opcode leaves rd untouched
        start(4'hF, 3, 1, 2, 1'b0, 32'd0, 128'd0, 1'b1, 1'b1);
        retire();
        check_reg("illegal_v3_kept", 3, vec4(32'd0, 32'd4, 32'd3, 32'd2));

        // Back-to-back with valid held; second acceptance coincides with a scalar write to its rs1
        drive_cmd(VEC_ADD, 5, 0, 0, 1'b0, 32'd0);
        @(posedge clk); #1;
        acc_a = cyc;
        push_exp(splat(32'd6), 1'b0);
        check("b2b_ready_exec", {127'b0, cmd_ready}, 0);
        drive_cmd(VEC_ADD, 6, 7, 0, 1'b0, 32'd0);
        @(posedge clk); #1;
        check("b2b_ready_wb", {127'b0, cmd_ready}, 0);
        @(posedge clk); #1;
        check("b2b_ready_idle", {127'b0, cmd_ready}, 1);
        wr_valid = 1'b1;
        wr_addr  = 3'd7;
        wr_data  = splat(32'h100);
        @(posedge clk); #1;
        acc_b = cyc;
        push_exp(splat(32'h33), 1'b0);
        cmd_valid = 1'b0;
        wr_valid  = 1'b0;
        check("b2b_spacing", acc_b - acc_a, 3);
        retire();
        check_reg("b2b_v5", 5, splat(32'd6));
        check_reg("b2b_v6_old_rs1", 6, splat(32'h33));
        check_reg("b2b_v7_written", 7, splat(32'h100));

        // Broadcast SUB (falls back to vreg[rs2] when broadcast is compiled out)
        wr(1, vec4(32'd7, 32'd0, 32'd5, 32'd10));
        wr(2, splat(32'd1));
`ifdef ZERORISCY_VEC_BCAST_EN
        start(VEC_SUB, 4, 1, 2, 1'b1, 32'd5, vec4(32'd2, 32'hFFFF_FFFB, 32'd0, 32'd5), 1'b0, 1'b1);
        retire();
        check_reg("bcast_v4", 4, vec4(32'd2, 32'hFFFF_FFFB, 32'd0, 32'd5));
`else
        start(VEC_SUB, 4, 1, 2, 1'b1, 32'd5, vec4(32'd6, 32'hFFFF_FFFF, 32'd4, 32'd9), 1'b0, 1'b1);
        retire();
        check_reg("nobcast_v4", 4, vec4(32'd6, 32'hFFFF_FFFF, 32'd4, 32'd9));
`endif

        // Reset while in EXEC aborts the instruction
        start(VEC_ADD, 3, 0, 0, 1'b0, 32'd0, 128'd0, 1'b0, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_busy", {127'b0, busy}, 0);
        check("abort_done", {127'b0, done}, 0);
        check_reg("abort_v0", 0, 0);
        check_reg("abort_v3", 3, 0);
        check_reg("abort_v4", 4, 0);
        repeat (4) @(posedge clk);
        #1;

        check("scoreboard_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
